// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-RAM arbiter: bus word, RAM progress codes
// and arbiter grant states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache request/response and RAM signals around the arbiter.
// slave: the arbiter itself. master: the caches and RAM around it.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Grant-duration counter: zero in the first cycle of a grant, counts up
// each grant cycle and flags the last cycle a grant may wait for ACCESS.
module mem_arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic first,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Elapsed-cycle counter, held at LAST once reached, cleared while idle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r != LAST) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign first  = (cnt_r == '0);
    assign expire = (cnt_r == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches and dcache accesses onto one single-ported RAM.
// Data wins by default; a pending fetch is forced through after MAX_DBURST
// data completions. Outputs are decoded from the registered grant state and
// the live requester signals, so completion data passes straight through.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT    = 64,
    parameter int MAX_DBURST = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam int BW = $clog2(MAX_DBURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBURST);

    arb_state_t    state_r;
    arb_state_t    state_next_s;
    logic [BW-1:0] burst_r;
    logic [BW-1:0] burst_next_s;
    logic          tmr_clear_s;
    logic          tmr_first_s;
    logic          tmr_expire_s;
    logic          dreq_s;
    logic          forced_s;
    logic          access_s;
    logic          fault_s;

    assign tmr_clear_s = (state_r == IDLE);
    assign dreq_s      = bus.dREN | bus.dWEN;
    assign forced_s    = bus.iREN & (burst_r == BURST_MAX);
    assign access_s    = (bus.ramstate == ACCESS);
    assign fault_s     = (bus.ramstate == ERROR) | tmr_expire_s;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (tmr_clear_s),
        .first  (tmr_first_s),
        .expire (tmr_expire_s)
    );

    // Grant state and data-burst counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            burst_r <= '0;
        end else begin
            state_r <= state_next_s;
            burst_r <= burst_next_s;
        end
    end

    // Arbitration, completion/abort decisions and bus output decode
    always_comb begin
        state_next_s = state_r;
        burst_next_s = burst_r;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0000_0000;
        bus.dwait    = 1'b1;
        bus.dload    = 32'h0000_0000;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0000_0000;
        bus.ramstore = 32'h0000_0000;
        bus.err      = 1'b0;
        case (state_r)
            IDLE: begin
                if (dreq_s && !forced_s) begin
                    state_next_s = DGRANT;
                end else if (bus.iREN) begin
                    state_next_s = IGRANT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    // fetch withdrawn (redirect): abandon quietly
                    state_next_s = IDLE;
                end else if (access_s) begin
                    bus.iwait    = 1'b0;
                    bus.iload    = bus.ramload;
                    burst_next_s = '0;
                    state_next_s = IDLE;
                end else if (fault_s) begin
                    bus.err      = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = IGRANT;
                end
            end
            DGRANT: begin
                bus.ramaddr = bus.daddr;
                if (bus.dWEN) begin
                    // a simultaneous read+write request is served as a write
                    bus.ramWEN   = 1'b1;
                    bus.ramstore = bus.dstore;
                end else begin
                    bus.ramREN = 1'b1;
                end
                bus.err = tmr_first_s & bus.dREN & bus.dWEN;
                if (!dreq_s) begin
                    state_next_s = IDLE;
                end else if (access_s) begin
                    bus.dwait = 1'b0;
                    if (!bus.dWEN) begin
                        bus.dload = bus.ramload;
                    end else begin
                        bus.dload = 32'h0000_0000;
                    end
                    if (bus.iREN && (burst_r != BURST_MAX)) begin
                        burst_next_s = burst_r + BW'(1);
                    end else begin
                        burst_next_s = burst_r;
                    end
                    state_next_s = IDLE;
                end else if (fault_s) begin
                    bus.err      = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DGRANT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM with programmable
// latency/fault mode, and per-scenario tasks checked against a grant-order
// model (data first unless a fetch has waited MAX_DBURST data completions).
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TIMEOUT    = 64;
    localparam int MAX_DBURST = 4;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ram_mode = 0;   // 0 normal, 1 stuck BUSY, 2 ERROR instead of ACCESS
    int   ram_lat  = 0;   // BUSY cycles before ACCESS
    int   ram_cnt  = 0;
    int   m_burst  = 0;   // model: data completions while a fetch waited
    int   both_low = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_DBURST(MAX_DBURST)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic word_t mem_val(input word_t a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Behavioural RAM: counts cycles of asserted controls, then reports ACCESS
    always begin
        @(posedge CLK);
        #2;
        if (RST || !(bus.ramREN || bus.ramWEN)) begin
            ram_cnt = 0;
            bus.ramstate = FREE;
            bus.ramload = $urandom;
        end else begin
            ram_cnt++;
            if (ram_mode == 1 || ram_cnt <= ram_lat) begin
                bus.ramstate = BUSY;
                bus.ramload = $urandom;
            end else if (ram_mode == 2) begin
                bus.ramstate = ERROR;
                bus.ramload = $urandom;
            end else begin
                bus.ramstate = ACCESS;
                bus.ramload = bus.ramREN ? mem_val(bus.ramaddr) : $urandom;
            end
        end
    end

    // Exclusive-wait monitor
    always @(negedge CLK) begin
        if (bus.iwait === 1'b0 && bus.dwait === 1'b0) both_low++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge CLK);
        n_checks++;
        if ({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err} !== 5'b11000)
            $display("FAIL reset_ctrl: got %b want 11000", {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err});
        else n_pass++;
        n_checks++;
        if ({bus.iload, bus.dload, bus.ramaddr, bus.ramstore} !== 128'h0)
            $display("FAIL reset_data: got %h want 0", {bus.iload, bus.dload, bus.ramaddr, bus.ramstore});
        else n_pass++;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_ifetch();
        int done_cyc = -1;
        int lows = 0;
        int bad_addr = 0;
        word_t got = 32'h0;
        ram_mode = 0; ram_lat = 3;
        bus.iaddr = 32'h0000_0040; bus.iREN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (bus.ramREN === 1'b1 && bus.ramaddr !== 32'h0000_0040) bad_addr++;
            if (bus.iwait === 1'b0) begin
                lows++;
                if (done_cyc < 0) begin done_cyc = c; got = bus.iload; end
            end
            @(posedge CLK); #1;
            if (done_cyc >= 0) bus.iREN = 1'b0;
        end
        n_checks++;
        if (done_cyc != 1 + ram_lat) $display("FAIL ifetch_latency: got %0d want %0d", done_cyc, 1 + ram_lat);
        else n_pass++;
        n_checks++;
        if (got !== 32'hDEAD_BEEF) $display("FAIL ifetch_data: got %h want deadbeef", got);
        else n_pass++;
        n_checks++;
        if (lows != 1) $display("FAIL ifetch_one_cycle: got %0d low cycles want 1", lows);
        else n_pass++;
        n_checks++;
        if (bad_addr != 0) $display("FAIL ifetch_addr: got %0d bad cycles want 0", bad_addr);
        else n_pass++;
    endtask

    task automatic test_dual_req();
        int d_cyc = -1;
        int i_cyc = -1;
        logic [65:0] first_ctl = '0;
        ram_mode = 0; ram_lat = $urandom_range(0, 3);
        bus.iaddr = 32'h0000_0100; bus.iREN = 1'b1;
        bus.daddr = 32'h0000_0080; bus.dstore = 32'h0000_1234; bus.dWEN = 1'b1;
        for (int c = 0; c < 30 && (i_cyc < 0 || d_cyc < 0); c++) begin
            @(negedge CLK);
            if (c == 1) first_ctl = {bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore};
            if (bus.dwait === 1'b0 && d_cyc < 0) d_cyc = c;
            if (bus.iwait === 1'b0 && i_cyc < 0) begin
                i_cyc = c;
                n_checks++;
                if (bus.iload !== mem_val(32'h0000_0100)) $display("FAIL dual_iload: got %h want %h", bus.iload, mem_val(32'h0000_0100));
                else n_pass++;
            end
            @(posedge CLK); #1;
            if (d_cyc >= 0) bus.dWEN = 1'b0;
            if (i_cyc >= 0) bus.iREN = 1'b0;
        end
        m_burst = 0;
        n_checks++;
        if (first_ctl !== {2'b10, 32'h0000_0080, 32'h0000_1234}) $display("FAIL dual_write_first: got %h want %h", first_ctl, {2'b10, 32'h0000_0080, 32'h0000_1234});
        else n_pass++;
        n_checks++;
        if (d_cyc != 1 + ram_lat) $display("FAIL dual_dwait_cycle: got %0d want %0d", d_cyc, 1 + ram_lat);
        else n_pass++;
        n_checks++;
        if (i_cyc != 3 + 2 * ram_lat) $display("FAIL dual_iwait_cycle: got %0d want %0d", i_cyc, 3 + 2 * ram_lat);
        else n_pass++;
    endtask

    task automatic test_burst();
        int nd = 0;
        int ni = 0;
        int k = 0;
        bit ireq = 1'b1;
        bit dreq = 1'b1;
        bit exp_d;
        bit seq_d [8];
        word_t ia, da;
        ram_mode = 0; ram_lat = $urandom_range(0, 2);
        ia = $urandom; da = $urandom;
        bus.iaddr = ia; bus.iREN = 1'b1;
        bus.daddr = da; bus.dREN = 1'b1; bus.dWEN = 1'b0;
        for (int c = 0; c < 120 && (ireq || dreq); c++) begin
            @(negedge CLK);
            if (bus.iwait === 1'b0 || bus.dwait === 1'b0) begin
                exp_d = dreq && !(ireq && m_burst == MAX_DBURST);
                if (k < 8) seq_d[k] = (bus.dwait === 1'b0);
                k++;
                n_checks++;
                if ((bus.dwait === 1'b0) !== exp_d) $display("FAIL burst_order: completion %0d got data=%0b want data=%0b", k, !bus.dwait, exp_d);
                else n_pass++;
                n_checks++;
                if (exp_d && bus.dload !== mem_val(da)) $display("FAIL burst_dload: got %h want %h", bus.dload, mem_val(da));
                else if (!exp_d && bus.iload !== mem_val(ia)) $display("FAIL burst_iload: got %h want %h", bus.iload, mem_val(ia));
                else n_pass++;
                if (exp_d) begin
                    nd++;
                    if (ireq && m_burst < MAX_DBURST) m_burst++;
                    if (nd == 6) dreq = 1'b0;
                end else begin
                    ni++; m_burst = 0; ireq = 1'b0;
                end
            end
            @(posedge CLK); #1;
            bus.iREN = ireq; bus.dREN = dreq;
            if (bus.dwait === 1'b0) begin da = $urandom; bus.daddr = da; end
        end
        n_checks++;
        if (k < 5 || seq_d[4] !== 1'b0) $display("FAIL burst_fifth_is_fetch: got completions=%0d fifth_data=%0b want fetch", k, (k >= 5) ? seq_d[4] : 1'b1);
        else n_pass++;
        n_checks++;
        if (nd != 6 || ni != 1) $display("FAIL burst_counts: got d=%0d i=%0d want d=6 i=1", nd, ni);
        else n_pass++;
    endtask

    task automatic test_drop();
        int lows = 0;
        int errs = 0;
        logic ren4 = 1'b1;
        ram_mode = 1;
        bus.iaddr = $urandom; bus.iREN = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            if (bus.iwait === 1'b0) lows++;
            if (bus.err === 1'b1) errs++;
            if (c == 4) ren4 = bus.ramREN;
            @(posedge CLK); #1;
            if (c == 2) bus.iREN = 1'b0;
        end
        ram_mode = 0;
        n_checks++;
        if (lows != 0 || errs != 0) $display("FAIL drop_quiet: got iwait_lows=%0d errs=%0d want 0 0", lows, errs);
        else n_pass++;
        n_checks++;
        if (ren4 !== 1'b0) $display("FAIL drop_ramREN: got %b want 0", ren4);
        else n_pass++;
    endtask

    task automatic test_rw_err();
        int errs = 0;
        int d_cyc = -1;
        logic [2:0] c1 = 3'b000;
        word_t ds;
        ram_mode = 0; ram_lat = 1;
        ds = $urandom;
        bus.daddr = $urandom; bus.dstore = ds; bus.dREN = 1'b1; bus.dWEN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (bus.err === 1'b1) errs++;
            if (c == 1) begin
                c1 = {bus.err, bus.ramWEN, bus.ramREN};
                n_checks++;
                if (bus.ramstore !== ds) $display("FAIL rw_store: got %h want %h", bus.ramstore, ds);
                else n_pass++;
            end
            if (bus.dwait === 1'b0 && d_cyc < 0) d_cyc = c;
            @(posedge CLK); #1;
            if (d_cyc >= 0) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; end
        end
        n_checks++;
        if (c1 !== 3'b110) $display("FAIL rw_first_cycle: got err/wen/ren=%b want 110", c1);
        else n_pass++;
        n_checks++;
        if (errs != 1 || d_cyc != 2) $display("FAIL rw_complete: got errs=%0d dwait_cycle=%0d want 1 2", errs, d_cyc);
        else n_pass++;
    endtask

    task automatic test_ram_error();
        int errs = 0;
        int err_cyc = -1;
        int lows = 0;
        logic ren4 = 1'b1;
        ram_mode = 2; ram_lat = 2;
        bus.daddr = $urandom; bus.dREN = 1'b1; bus.dWEN = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            if (bus.err === 1'b1) begin errs++; if (err_cyc < 0) err_cyc = c; end
            if (bus.dwait === 1'b0) lows++;
            if (c == 4) ren4 = bus.ramREN;
            @(posedge CLK); #1;
            if (err_cyc >= 0) bus.dREN = 1'b0;
        end
        ram_mode = 0;
        n_checks++;
        if (errs != 1 || err_cyc != 1 + ram_lat) $display("FAIL ramerr_pulse: got errs=%0d cycle=%0d want 1 %0d", errs, err_cyc, 1 + ram_lat);
        else n_pass++;
        n_checks++;
        if (lows != 0 || ren4 !== 1'b0) $display("FAIL ramerr_abort: got dwait_lows=%0d ramREN=%b want 0 0", lows, ren4);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int errs = 0;
        int err_cyc = -1;
        int i_cyc = -1;
        int lows = 0;
        logic [33:0] regrant = '0;
        logic idle_ren = 1'b1;
        word_t ia;
        ram_mode = 1; ram_lat = 0;
        ia = $urandom;
        bus.iaddr = ia; bus.iREN = 1'b1;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            @(negedge CLK);
            if (bus.err === 1'b1) begin errs++; if (err_cyc < 0) err_cyc = c; end
            if (bus.iwait === 1'b0) begin lows++; if (i_cyc < 0) i_cyc = c; end
            if (c == TIMEOUT + 1) idle_ren = bus.ramREN;
            if (c == TIMEOUT + 2) regrant = {bus.ramREN, bus.ramWEN, bus.ramaddr};
            @(posedge CLK); #1;
            if (c == TIMEOUT + 2) ram_mode = 0;
            if (i_cyc >= 0) bus.iREN = 1'b0;
        end
        n_checks++;
        if (errs != 1 || err_cyc != TIMEOUT) $display("FAIL timeout_err: got errs=%0d cycle=%0d want 1 %0d", errs, err_cyc, TIMEOUT);
        else n_pass++;
        n_checks++;
        if (idle_ren !== 1'b0) $display("FAIL timeout_idle: got ramREN=%b want 0", idle_ren);
        else n_pass++;
        n_checks++;
        if (regrant !== {2'b10, ia}) $display("FAIL timeout_regrant: got %h want %h", regrant, {2'b10, ia});
        else n_pass++;
        n_checks++;
        if (lows != 1 || i_cyc != TIMEOUT + 3) $display("FAIL timeout_retry_done: got lows=%0d cycle=%0d want 1 %0d", lows, i_cyc, TIMEOUT + 3);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ireq, dreq, exp_d, gd;
        int rd, next_cyc, stuck;
        word_t ia, da, ds;
        stuck = 0;
        for (int r = 0; r < 16; r++) begin
            ram_mode = 0; ram_lat = $urandom_range(0, 4);
            ireq = ($urandom_range(0, 1) == 1);
            rd = $urandom_range(0, 2);
            if (!ireq && rd == 0) ireq = 1'b1;
            dreq = (rd != 0);
            ia = $urandom; da = $urandom; ds = $urandom;
            bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
            bus.iREN = ireq; bus.dREN = (rd == 1); bus.dWEN = (rd == 2);
            next_cyc = 1 + ram_lat;
            for (int c = 0; c < 40 && (ireq || dreq); c++) begin
                @(negedge CLK);
                if (bus.iwait === 1'b0 || bus.dwait === 1'b0) begin
                    gd = (bus.dwait === 1'b0);
                    exp_d = dreq && !(ireq && m_burst == MAX_DBURST);
                    n_checks++;
                    if (gd !== exp_d || c != next_cyc) $display("FAIL rand_order: round %0d got data=%0b cycle=%0d want data=%0b cycle=%0d", r, gd, c, exp_d, next_cyc);
                    else n_pass++;
                    n_checks++;
                    if (exp_d && rd == 1 && bus.dload !== mem_val(da)) $display("FAIL rand_dload: got %h want %h", bus.dload, mem_val(da));
                    else if (exp_d && rd == 2 && {bus.ramWEN, bus.ramaddr, bus.ramstore} !== {1'b1, da, ds}) $display("FAIL rand_write: got %h want %h", {bus.ramWEN, bus.ramaddr, bus.ramstore}, {1'b1, da, ds});
                    else if (!exp_d && bus.iload !== mem_val(ia)) $display("FAIL rand_iload: got %h want %h", bus.iload, mem_val(ia));
                    else n_pass++;
                    if (exp_d) begin
                        if (ireq && m_burst < MAX_DBURST) m_burst++;
                        dreq = 1'b0;
                    end else begin
                        m_burst = 0; ireq = 1'b0;
                    end
                    next_cyc = c + 2 + ram_lat;
                end
                @(posedge CLK); #1;
                bus.iREN = ireq; bus.dREN = dreq && (rd == 1); bus.dWEN = dreq && (rd == 2);
            end
            if (ireq || dreq) stuck++;
            bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        end
        n_checks++;
        if (stuck != 0) $display("FAIL rand_budget: got %0d unfinished rounds want 0", stuck);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic wen1 = 1'b0;
        int i_cyc = -1;
        word_t ia, iload_got;
        iload_got = 32'h0;
        ram_mode = 1;
        ia = $urandom;
        bus.iaddr = ia; bus.iREN = 1'b1;
        bus.daddr = $urandom; bus.dstore = $urandom; bus.dWEN = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        wen1 = bus.ramWEN;
        #1 RST = 1'b1;
        #1;
        n_checks++;
        if (wen1 !== 1'b1) $display("FAIL rstmid_granted: got ramWEN=%b want 1", wen1);
        else n_pass++;
        n_checks++;
        if ({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err} !== 5'b11000 ||
            {bus.iload, bus.dload, bus.ramaddr, bus.ramstore} !== 128'h0)
            $display("FAIL rstmid_outputs: got ctl=%b data=%h want 11000 0", {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err}, {bus.iload, bus.dload, bus.ramaddr, bus.ramstore});
        else n_pass++;
        bus.dWEN = 1'b0;
        m_burst = 0;
        @(posedge CLK); #1;
        RST = 1'b0; ram_mode = 0; ram_lat = 2;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            if (bus.iwait === 1'b0 && i_cyc < 0) begin i_cyc = c; iload_got = bus.iload; end
            @(posedge CLK); #1;
            if (i_cyc >= 0) bus.iREN = 1'b0;
        end
        n_checks++;
        if (i_cyc != 1 + ram_lat || iload_got !== mem_val(ia)) $display("FAIL rstmid_refetch: got cycle=%0d data=%h want %0d %h", i_cyc, iload_got, 1 + ram_lat, mem_val(ia));
        else n_pass++;
    endtask

    task automatic test_exclusive_waits();
        n_checks++;
        if (both_low != 0) $display("FAIL waits_exclusive: got %0d cycles with both low want 0", both_low);
        else n_pass++;
    endtask

    initial begin
        RST = 1'b1;
        bus.iREN = 1'b0; bus.iaddr = 32'h0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
        bus.ramstate = FREE; bus.ramload = 32'h0;
        test_reset();
        test_ifetch();
        test_dual_req();
        test_burst();
        test_drop();
        test_rw_err();
        test_ram_error();
        test_timeout();
        test_random();
        test_reset_mid();
        test_exclusive_waits();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
